// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the 8-bit ALU and its request
//                sequencer: operand width, opcode encodings, sequencer FSM
//                state encoding and the round-robin grant helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Operand/result width of alu_8bits; the sequencer's W must match it.
  localparam int ALU_W = 8;

  // Opcodes, presented unchanged on the ALU S input.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Sequencer FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Two-way round-robin pick: a lone requester wins outright; on a tie the
  // requester that was not served last wins. With no request the result is
  // a don't-care (0), because ready is also qualified by valid.
  function automatic logic pick_grant(input logic [1:0] valid,
                                      input logic       last_served);
    logic g;
    if (valid == 2'b11) begin
      g = ~last_served;
    end else begin
      g = valid[1];
    end
    return g;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_8bits.sv
`default_nettype none
// ============================================================================
//  Module      : alu_8bits
//  Description : Shared 8-bit combinational ALU. ADD/SUB/AND/OR selected by
//                S; carry and borrow are discarded so arithmetic wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_8bits
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [1:0]       S,
  output logic [ALU_W-1:0] Result
);

  // Pure combinational opcode decode; results truncate to ALU_W bits.
  always_comb begin
    Result = '0;
    case (S)
      OP_ADD:  Result = a + b;
      OP_SUB:  Result = a - b;
      OP_AND:  Result = a & b;
      OP_OR:   Result = a | b;
      default: Result = '0;
    endcase
  end

endmodule : alu_8bits
`default_nettype wire

// File: rtl/alu_share_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_sequencer
//  Description : Two-requester round-robin front end for alu_8bits. Accepts
//                one request in IDLE, registers its operands into the ALU
//                for one EXEC cycle, then holds the tagged result in RESP
//                until the consumer takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_sequencer
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int CNT_W = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [W-1:0]     req_a0,
  input  logic [W-1:0]     req_b0,
  input  logic [1:0]       req_op0,
  input  logic [W-1:0]     req_a1,
  input  logic [W-1:0]     req_b1,
  input  logic [1:0]       req_op1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // FSM and arbiter state
  state_t           r_state;
  logic             r_last_served;

  // Operand registers: the only source feeding the ALU
  logic [W-1:0]     r_op_a;
  logic [W-1:0]     r_op_b;
  logic [1:0]       r_op_s;
  logic             r_op_id;

  // Registered response side
  logic [W-1:0]     r_rsp_data;
  logic             r_rsp_id;
  logic             r_rsp_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_op_count;

  // Arbiter and datapath wires
  logic             w_grant;
  logic [1:0]       w_req_ready;
  logic             w_accept;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic [1:0]       w_sel_op;
  logic [W-1:0]     w_alu_result;

  // Grant and operand select; ready only depends on state and req_valid,
  // so there is never a combinational path from rsp_ready to req_ready.
  always_comb begin
    w_grant     = pick_grant(req_valid, r_last_served);
    w_req_ready = 2'b00;
    if (r_state == ST_IDLE) begin
      w_req_ready = req_valid & (w_grant ? 2'b10 : 2'b01);
    end
    w_accept = |w_req_ready;
    w_sel_a  = w_grant ? req_a1  : req_a0;
    w_sel_b  = w_grant ? req_b1  : req_b0;
    w_sel_op = w_grant ? req_op1 : req_op0;
  end

  alu_8bits u_alu (
    .a      (r_op_a),
    .b      (r_op_b),
    .S      (r_op_s),
    .Result (w_alu_result)
  );

  // Sequencer FSM: IDLE accepts, EXEC captures the ALU result, RESP holds
  // it until the handshake. Reset drops any in-flight operation uncounted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_last_served <= 1'b1;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_op_s        <= OP_ADD;
      r_op_id       <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_id      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_op_count    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op_a        <= w_sel_a;
            r_op_b        <= w_sel_b;
            r_op_s        <= w_sel_op;
            r_op_id       <= w_grant;
            r_last_served <= w_grant;
            r_busy        <= 1'b1;
            r_state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= w_alu_result;
          r_rsp_id    <= r_op_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_op_count  <= r_op_count + C_CNT_ONE;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_busy;
  assign op_count  = r_op_count;

endmodule : alu_share_sequencer
`default_nettype wire

// File: tb/tb_alu_share_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_sequencer
//  Description : Directed self-checking bench for alu_share_sequencer.
//                The counter width is reduced so that wrap-around is
//                reachable in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_sequencer;

  localparam int W     = 8;
  localparam int CNT_W = 10;
  localparam int N_WRAP = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [W-1:0]     req_a0, req_b0, req_a1, req_b1;
  logic [1:0]       req_op0, req_op1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic             rsp_id;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_sequencer #(
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_op0   (req_op0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_op1   (req_op1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  int n_high;
  int n_bad_gap;
  int last_high;
  logic [31:0] cnt_before_wrap;
  logic [31:0] first_data;

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_a0 = '0; req_b0 = '0; req_op0 = 2'b00;
    req_a1 = '0; req_b1 = '0; req_op1 = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_ready", req_ready, 2'b00);
    check("rst_valid", rsp_valid, 0);
    check("rst_data",  rsp_data, 0);
    check("rst_id",    rsp_id, 0);
    check("rst_busy",  busy, 0);
    check("rst_cnt",   op_count, 0);

    // Single request: 0xF0 + 0x20 wraps to 0x10
    req_a0 = 8'hF0; req_b0 = 8'h20; req_op0 = 2'b00;
    req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    check("t1_ready", req_ready, 2'b01);
    tick();                     // accept edge
    req_valid = 2'b00;
    check("t1_busy_exec", busy, 1);
    check("t1_valid_exec", rsp_valid, 0);
    check("t1_ready_exec", req_ready, 2'b00);
    tick();                     // capture edge
    check("t1_valid", rsp_valid, 1);
    check("t1_data", rsp_data, 8'h10);
    check("t1_id", rsp_id, 0);
    tick();                     // handshake edge
    check("t1_valid_done", rsp_valid, 0);
    check("t1_cnt", op_count, 1);
    check("t1_busy_done", busy, 0);

    // Tie from reset, then round robin
    do_reset();
    req_a0 = 8'h05; req_b0 = 8'h07; req_op0 = 2'b01;
    req_a1 = 8'hCC; req_b1 = 8'h0F; req_op1 = 2'b10;
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    check("t2_tie1", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    tick();
    check("t2_r0_data", rsp_data, 8'hFE);
    check("t2_r0_id", rsp_id, 0);
    check("t2_r0_ready", req_ready, 2'b00);
    tick();
    check("t2_r1_grant", req_ready, 2'b10);
    tick();                     // requester 1 accepted
    req_a0 = 8'h01; req_b0 = 8'h02; req_op0 = 2'b00;
    req_a1 = 8'h10; req_b1 = 8'h01; req_op1 = 2'b01;
    req_valid = 2'b11;
    tick();
    check("t2_r1_data", rsp_data, 8'h0C);
    check("t2_r1_id", rsp_id, 1);
    tick();
    check("t2_tie2", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    tick();
    check("t2_add_data", rsp_data, 8'h03);
    check("t2_add_id", rsp_id, 0);
    tick();
    check("t2_rr_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    check("t2_sub_data", rsp_data, 8'h0F);
    check("t2_sub_id", rsp_id, 1);
    tick();
    check("t2_cnt", op_count, 4);

    // Backpressure: 0x3C | 0x0F = 0x3F held for 5 cycles
    rsp_ready = 1'b0;
    req_a0 = 8'h3C; req_b0 = 8'h0F; req_op0 = 2'b11;
    req_valid = 2'b01;
    tick();
    req_a1 = 8'h55; req_b1 = 8'hAA; req_op1 = 2'b10;
    req_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 8'h3F);
      check("bp_id", rsp_id, 0);
      check("bp_ready", req_ready, 2'b00);
      check("bp_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_done_valid", rsp_valid, 0);
    check("bp_done_cnt", op_count, 5);
    check("bp_next_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    check("bp_r1_data", rsp_data, 8'h00);
    check("bp_r1_id", rsp_id, 1);
    tick();
    check("bp_cnt", op_count, 6);

    // Reset during EXEC of OR 0x81,0x18
    req_a0 = 8'h81; req_b0 = 8'h18; req_op0 = 2'b11;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    check("rx_busy_exec", busy, 1);
    rst = 1'b1;
    #1;
    check("rx_valid", rsp_valid, 0);
    check("rx_busy", busy, 0);
    check("rx_cnt", op_count, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rx_no_valid", rsp_valid, 0);
      check("rx_no_data", rsp_data, 0);
    end
    check("rx_cnt_after", op_count, 0);

    // Withdrawn request while busy
    rsp_ready = 1'b0;
    req_a0 = 8'h01; req_b0 = 8'h01; req_op0 = 2'b00;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    check("wd_ready_resp", req_ready, 2'b00);
    rsp_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("wd_ready_idle", req_ready, 2'b00);
      check("wd_busy_idle", busy, 0);
      check("wd_valid_idle", rsp_valid, 0);
      tick();
    end
    check("wd_cnt", op_count, 1);

    // Counter wrap and throughput with rsp_ready tied high
    do_reset();
    req_a0 = 8'h01; req_b0 = 8'h01; req_op0 = 2'b00;
    req_valid = 2'b01; rsp_ready = 1'b1;
    n_high = 0; n_bad_gap = 0; last_high = 0;
    cnt_before_wrap = 0; first_data = 0;
    for (int cyc = 1; cyc <= 3 * N_WRAP; cyc++) begin
      tick();
      if (rsp_valid) begin
        if (n_high == 0) first_data = 32'(rsp_data);
        if (last_high != 0 && (cyc - last_high) != 3) n_bad_gap++;
        last_high = cyc;
        n_high++;
      end
      if (cyc == 3 * N_WRAP - 3) cnt_before_wrap = 32'(op_count);
      if (cyc == 3 * N_WRAP) req_valid = 2'b00;
    end
    check("wrap_first_data", first_data, 8'h02);
    check("wrap_first_at", (n_high > 0) ? 1 : 0, 1);
    check("wrap_rsp_count", n_high, N_WRAP);
    check("wrap_gap_bad", n_bad_gap, 0);
    check("wrap_pre_cnt", cnt_before_wrap, N_WRAP - 1);
    check("wrap_cnt", op_count, 0);
    tick();
    check("wrap_idle_busy", busy, 0);
    check("wrap_idle_ready", req_ready, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_share_sequencer
`default_nettype wire

// File: doc/alu_share_sequencer.md
# alu_share_sequencer

Two-requester front end for the shared 8-bit combinational ALU (`alu_8bits`). Each requester presents an operand pair and an opcode over a valid/ready handshake. The block arbitrates round-robin, registers the winning operands into the ALU, and captures the result. It returns the result over a valid/ready response channel tagged with the requester ID. It sits between the top-level pin mux and the ALU, so the ALU never sees unregistered or contending inputs.

## Interface
Parameters:
- `W`, 8, operand/result width; must match `alu_8bits`.
- `CNT_W`, 16, width of the completed-operation counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid; bit i is requester i.
- `req_ready`  out  2  per-requester accept; at most one bit is high in any cycle.
- `req_a0`, `req_b0`  in  W  operands from requester 0.
- `req_op0`  in  2  opcode from requester 0.
- `req_a1`, `req_b1`  in  W  operands from requester 1.
- `req_op1`  in  2  opcode from requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  W  ALU result.
- `rsp_id`  out  1  requester that owns `rsp_data`.
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W.

## Operation
- Opcodes, passed unchanged to the ALU `S` input:
  - 00 ADD, 01 SUB, 10 AND, 11 OR.
  - Results are W bits; carry and borrow are discarded, so results wrap.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The arbiter picks the grant combinationally.
  - If only one `req_valid` bit is set, that requester is granted.
  - If both are set, the requester that was not last served is granted.
  - `req_ready[grant]` = 1 only when that requester's `req_valid` is set.
  - On accept (valid & ready):
    - latch a, b, op and id into the operand registers;
    - set `last_served` = id;
    - go to EXEC.
- EXEC:
  - The operand registers drive `alu_8bits`.
  - On the edge, capture `Result` into `rsp_data` and id into `rsp_id`.
  - Go to RESP.
- RESP:
  - `rsp_valid` = 1, and `rsp_data`/`rsp_id` are held stable.
  - On `rsp_valid & rsp_ready`: increment `op_count`, go to IDLE.
  - Otherwise stay in RESP indefinitely; no backpressure timeout.
- `req_ready` is 0 in EXEC and RESP. Requests that arrive meanwhile wait; requesters must hold `req_valid` and their operands until accepted.
- A requester dropping `req_valid` before acceptance is legal. The arbiter simply re-evaluates.

## Timing
- Reset values: state = IDLE, `last_served` = 1 (requester 0 wins the first tie), `req_ready` = 00 until requests arrive, `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `busy` = 0, `op_count` = 0.
- Latency: accept at edge N → EXEC during cycle N+1 → `rsp_valid` high from N+2.
- Throughput: with `rsp_ready` tied high, one operation per 3 cycles (IDLE, EXEC, RESP).
- No combinational path from `rsp_ready` to `req_ready`. A new accept occurs no earlier than the cycle after the response handshake.
- Reset asserted mid-operation, in any state: everything returns to reset values immediately; the in-flight result is dropped and not counted.
- Counter wrap: 0xFFFF + 1 → 0x0000, with no flag.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode constants `OP_ADD`/`OP_SUB`/`OP_AND`/`OP_OR`;
  - the FSM state encoding `ST_IDLE`/`ST_EXEC`/`ST_RESP`;
  - the operand width constant used by both this block and `alu_8bits`.
- Exactly one sub-module: `alu_8bits`, instantiated once with ports `a`, `b`, `S`, `Result`. It is driven only from the operand registers.
- The arbiter (grant logic and `last_served` register) is inline; no separate module.

## Test plan
- Single request: requester 0 sends a=0xF0, b=0x20, op=ADD → `rsp_data`=0x10 (wrap), `rsp_id`=0, `rsp_valid` first high 2 cycles after accept, `op_count`=1.
- Tie and round-robin: both valid from reset; requester 0 sends SUB 0x05,0x07 and requester 1 sends AND 0xCC,0x0F → first response 0xFE id 0, second response 0x0C id 1; the next tie grants requester 0.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` rises → data and id held stable, `req_ready`=00 throughout, `busy`=1; completion when `rsp_ready`=1.
- Reset mid-EXEC: assert `rst` during EXEC of an OR 0x81,0x18 → next cycle `rsp_valid`=0, `busy`=0, `op_count` unchanged at 0, the OR result is never presented.
- Counter wrap: preload via 65536 back-to-back ADD ops with `rsp_ready` tied high → `op_count` returns to 0x0000; throughput is exactly one response per 3 cycles.
- Withdrawn request: requester 1 raises then drops `req_valid` while the block is busy → no spurious grant; the block stays in IDLE with `req_ready`=00.
